// File: rtl/cam_tx_pkg.sv
// Shared encodings for the DVP test-pattern transmitter: FSM states, pattern mode codes,
// colour-bar table and LFSR constants (LFSR used only when CAM_TX_LFSR_EN is defined).
package cam_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_t;

  localparam logic [1:0] MODE_BARS  = 2'd0;
  localparam logic [1:0] MODE_GREY  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_SOLID = 2'd3;

  // Index 0 is the leftmost bar (white), index 7 the rightmost (black).
  localparam logic [7:0][15:0] BAR_TABLE = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F,
    16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };

  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 0,2,3,5 of a right-shifting register.
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {^(v & LFSR_TAP_MASK), v[15:1]};
  endfunction

endpackage

// File: rtl/cam_stream_tx_if.sv
// DVP camera bus: byte clock, frame/line syncs and the pixel byte.
interface cam_stream_tx_if;
  logic       pclk;
  logic       vsync;
  logic       href;
  logic [7:0] data;

  modport master (output pclk, output vsync, output href, output data);
  modport slave  (input  pclk, input  vsync, input  href, input  data);
endinterface

// File: rtl/cam_tx_pattern.sv
// Combinational RGB565 pattern generator: (x, y, mode, mode-3 colour) -> pixel.
module cam_tx_pattern
  import cam_tx_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [1:0]  mode,
  input  logic [15:0] mode3_pix,
  output logic [15:0] pix
);

  localparam logic [15:0] BAR_W = 16'(H_ACTIVE / 8);

  logic [15:0] bar_idx;
  logic [7:0]  grey;
  logic        unused_bits;

  assign bar_idx     = x / BAR_W;
  assign grey        = x[7:0];
  assign unused_bits = ^{bar_idx[15:3], y[15:4], y[2:0]};

  always_comb begin
    pix = 16'h0000;
    case (mode)
      MODE_BARS:  pix = BAR_TABLE[bar_idx[2:0]];
      MODE_GREY:  pix = {grey[7:3], grey[7:2], grey[7:3]};
      MODE_CHECK: pix = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
      default:    pix = mode3_pix;
    endcase
  end

endmodule

// File: rtl/cam_stream_tx.sv
// OV7670-style DVP transmitter emitting RGB565 test patterns, high byte first.
// Define CAM_TX_LFSR_EN to make mode 3 emit a per-frame-reseeded LFSR instead of solid_color.
module cam_stream_tx
  import cam_tx_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [15:0]      solid_color,
  cam_stream_tx_if.master  dvp,
  output logic [15:0]      frame_count,
  output logic             busy
);

  localparam int LINE_SLOTS = 2 * (H_ACTIVE + H_BLANK);
  localparam int HW         = $clog2(LINE_SLOTS);
  localparam int MAX_AB     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int MAX_CD     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int MAX_LINES  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int LW         = ($clog2(MAX_LINES) > 0) ? $clog2(MAX_LINES) : 1;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [LW-1:0]   line_q, line_d;
  logic            phase_q, phase_d;
  logic            vsync_q, vsync_d, href_q, href_d, busy_q, busy_d;
  logic [7:0]      data_q, data_d;
  logic [15:0]     fc_q, fc_d;
  logic [1:0]      mode_q, mode_d;
  logic [15:0]     mode3_src, pix;
  logic            frame_start, line_end, phase_end;

`ifdef CAM_TX_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        unused_solid;
  assign unused_solid = ^solid_color;
  assign mode3_src    = lfsr_d;
`else
  logic [15:0] solid_q, solid_d;
  assign mode3_src = solid_d;
`endif

  function automatic int phase_lines(input state_t s);
    case (s)
      ST_VSYNC:  return VSYNC_LINES;
      ST_VBACK:  return V_BACK;
      ST_ACTIVE: return V_ACTIVE;
      ST_VFRONT: return V_FRONT;
      default:   return 1;
    endcase
  endfunction

  assign line_end  = (h_q == HW'(LINE_SLOTS - 1));
  assign phase_end = line_end && (line_q == LW'(phase_lines(state_q) - 1));

  // Timing state only moves on the edge where pclk falls (phase 1 -> 0).
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    line_d      = line_q;
    fc_d        = fc_q;
    mode_d      = mode_q;
    phase_d     = ~phase_q;
    frame_start = 1'b0;
`ifdef CAM_TX_LFSR_EN
    lfsr_d      = lfsr_q;
`else
    solid_d     = solid_q;
`endif
    if (phase_q) begin
      if (state_q == ST_IDLE) begin
        frame_start = enable;
      end else begin
        h_d = line_end ? '0 : h_q + 1'b1;
        if (line_end) line_d = line_q + 1'b1;
        if (phase_end) begin
          line_d = '0;
          case (state_q)
            ST_VSYNC:  state_d = ST_VBACK;
            ST_VBACK:  state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_VFRONT;
            default: begin
              fc_d = fc_q + 16'd1;
              if (enable) frame_start = 1'b1;
              else        state_d     = ST_IDLE;
            end
          endcase
        end
      end
      if (frame_start) begin
        state_d = ST_VSYNC;
        h_d     = '0;
        line_d  = '0;
        mode_d  = mode;
`ifdef CAM_TX_LFSR_EN
        lfsr_d  = LFSR_SEED;
      end else if (state_q == ST_ACTIVE && h_q[0] && h_q < HW'(2 * H_ACTIVE)) begin
        lfsr_d  = lfsr_step(lfsr_q);
`else
        solid_d = solid_color;
`endif
      end
    end
  end

  cam_tx_pattern #(.H_ACTIVE(H_ACTIVE)) u_pattern (
    .x         (16'(h_d[HW-1:1])),
    .y         (16'(line_d)),
    .mode      (mode_d),
    .mode3_pix (mode3_src),
    .pix       (pix)
  );

  // Outputs are registered from the upcoming slot so they change together with the counters.
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    vsync_d = (state_d == ST_VSYNC);
    href_d  = (state_d == ST_ACTIVE) && (h_d < HW'(2 * H_ACTIVE));
    data_d  = 8'h00;
    if (href_d) data_d = h_d[0] ? pix[7:0] : pix[15:8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      line_q  <= '0;
      phase_q <= 1'b0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= 8'h00;
      fc_q    <= 16'h0000;
      mode_q  <= 2'd0;
`ifdef CAM_TX_LFSR_EN
      lfsr_q  <= LFSR_SEED;
`else
      solid_q <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      line_q  <= line_d;
      phase_q <= phase_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      fc_q    <= fc_d;
      mode_q  <= mode_d;
`ifdef CAM_TX_LFSR_EN
      lfsr_q  <= lfsr_d;
`else
      solid_q <= solid_d;
`endif
    end
  end

  assign dvp.pclk    = phase_q;
  assign dvp.vsync   = vsync_q;
  assign dvp.href    = href_q;
  assign dvp.data    = data_q;
  assign frame_count = fc_q;
  assign busy        = busy_q;

endmodule
